// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmit serializer among N_REQ requesters.
// When idle, it picks the next pending requester after the last winner. It latches
// that requester's byte and config as a complete frame, then shifts the frame out LSB
// first, one bit per baud tick.
//
// Ports:
//   i_clock      system clock, rising edge
//   i_rst        synchronous active-high reset
//   i_baud_tick  one-cycle bit-rate enable
//   i_req        per-requester level request
//   i_req_data   byte for requester i at [8i+7:8i]
//   i_req_cfg    requester i config at [4i+3:4i] = {parity_type[1:0], stop_bits, data_length}
//   o_grant      one-hot, high while that requester's frame is in flight
//   o_ack        one-cycle pulse when a requester's data/cfg are latched
//   o_done       one-cycle pulse when a requester's frame completes
//   o_busy_id    index of the granted requester (valid while o_tx_active)
//   o_tx_serial  serial output, idle high
//   o_tx_active  high from latch until frame completion
module uart_tx_scheduler #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDW   = 1
) (
  input  logic               i_clock,
  input  logic               i_rst,
  input  logic               i_baud_tick,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [4*N_REQ-1:0] i_req_cfg,
  output logic [N_REQ-1:0]   o_grant,
  output logic [N_REQ-1:0]   o_ack,
  output logic [N_REQ-1:0]   o_done,
  output logic [IDW-1:0]     o_busy_id,
  output logic               o_tx_serial,
  output logic               o_tx_active
);

  // The reset pointer value makes requester 0 the first one searched.
  localparam logic [IDW-1:0] RrInit = IDW'(N_REQ - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            r_state;
  logic [11:0]       r_frame;
  logic [3:0]        r_len;
  logic [3:0]        r_bit_cnt;
  logic              r_tx_serial;
  logic [N_REQ-1:0]  r_grant;
  logic [N_REQ-1:0]  r_ack;
  logic [N_REQ-1:0]  r_done;
  logic [IDW-1:0]    r_busy_id;
  logic              r_tx_active;
  logic [IDW-1:0]    r_rr;

  state_e            w_state_nxt;
  logic [11:0]       w_frame_nxt;
  logic [3:0]        w_len_nxt;
  logic [3:0]        w_bit_cnt_nxt;
  logic              w_tx_serial_nxt;
  logic [N_REQ-1:0]  w_grant_nxt;
  logic [N_REQ-1:0]  w_ack_nxt;
  logic [N_REQ-1:0]  w_done_nxt;
  logic [IDW-1:0]    w_busy_id_nxt;
  logic              w_tx_active_nxt;
  logic [IDW-1:0]    w_rr_nxt;

  // Arbitration results
  logic              w_found;
  logic [IDW-1:0]    w_win;
  logic [N_REQ-1:0]  w_win_oh;
  logic [7:0]        w_win_data;
  logic [3:0]        w_win_cfg;

  // Frame built from the winner's byte and config
  logic              w_dl;
  logic              w_sb;
  logic [1:0]        w_pt;
  logic              w_par_en;
  logic              w_data_xor;
  logic              w_par_bit;
  logic [11:0]       w_frame;
  logic [3:0]        w_len;

  // Two passes: first only indices above the last winner, then wrap to all.
  always_comb begin
    w_found    = 1'b0;
    w_win      = '0;
    w_win_oh   = '0;
    w_win_data = '0;
    w_win_cfg  = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < int'(N_REQ); i++) begin
        if (!w_found && i_req[i] && (p == 1 || i > int'(r_rr))) begin
          w_found     = 1'b1;
          w_win       = IDW'(i);
          w_win_oh[i] = 1'b1;
          w_win_data  = i_req_data[8*i +: 8];
          w_win_cfg   = i_req_cfg[4*i +: 4];
        end
      end
    end
  end

  always_comb begin
    w_dl       = w_win_cfg[0];
    w_sb       = w_win_cfg[1];
    w_pt       = w_win_cfg[3:2];
    w_par_en   = (w_pt == 2'b01) || (w_pt == 2'b10);
    w_data_xor = w_dl ? ^w_win_data : ^w_win_data[6:0];
    // Odd parity inverts the data XOR so the total count of ones is odd.
    w_par_bit  = (w_pt == 2'b01) ? ~w_data_xor : w_data_xor;

    // Unused tail positions stay 1, so they double as stop bits.
    w_frame      = '1;
    w_frame[0]   = 1'b0;
    w_frame[7:1] = w_win_data[6:0];
    if (w_dl) begin
      w_frame[8] = w_win_data[7];
    end
    if (w_par_en) begin
      if (w_dl) begin
        w_frame[9] = w_par_bit;
      end else begin
        w_frame[8] = w_par_bit;
      end
    end
    w_len = 4'd9 + {3'b000, w_dl} + {3'b000, w_par_en} + {3'b000, w_sb};
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_frame_nxt     = r_frame;
    w_len_nxt       = r_len;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_tx_serial_nxt = r_tx_serial;
    w_grant_nxt     = r_grant;
    w_ack_nxt       = '0;
    w_done_nxt      = '0;
    w_busy_id_nxt   = r_busy_id;
    w_tx_active_nxt = r_tx_active;
    w_rr_nxt        = r_rr;

    unique case (r_state)
      StIdle: begin
        w_tx_serial_nxt = 1'b1;
        // A tick in the latch cycle is ignored; timing starts at the next tick.
        if (w_found) begin
          w_frame_nxt     = w_frame;
          w_len_nxt       = w_len;
          w_bit_cnt_nxt   = '0;
          w_grant_nxt     = w_win_oh;
          w_ack_nxt       = w_win_oh;
          w_busy_id_nxt   = w_win;
          w_tx_active_nxt = 1'b1;
          w_rr_nxt        = w_win;
          w_state_nxt     = StSend;
        end
      end
      StSend: begin
        if (i_baud_tick) begin
          if (r_bit_cnt == r_len) begin
            // The tick after the last bit ends the frame.
            w_tx_serial_nxt = 1'b1;
            w_grant_nxt     = '0;
            w_tx_active_nxt = 1'b0;
            w_done_nxt      = r_grant;
            w_state_nxt     = StIdle;
          end else begin
            w_tx_serial_nxt = r_frame[r_bit_cnt];
            w_bit_cnt_nxt   = r_bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_frame     <= '1;
      r_len       <= 4'd9;
      r_bit_cnt   <= '0;
      r_tx_serial <= 1'b1;
      r_grant     <= '0;
      r_ack       <= '0;
      r_done      <= '0;
      r_busy_id   <= '0;
      r_tx_active <= 1'b0;
      r_rr        <= RrInit;
    end else begin
      r_state     <= w_state_nxt;
      r_frame     <= w_frame_nxt;
      r_len       <= w_len_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_tx_serial <= w_tx_serial_nxt;
      r_grant     <= w_grant_nxt;
      r_ack       <= w_ack_nxt;
      r_done      <= w_done_nxt;
      r_busy_id   <= w_busy_id_nxt;
      r_tx_active <= w_tx_active_nxt;
      r_rr        <= w_rr_nxt;
    end
  end

  assign o_grant     = r_grant;
  assign o_ack       = r_ack;
  assign o_done      = r_done;
  assign o_busy_id   = r_busy_id;
  assign o_tx_serial = r_tx_serial;
  assign o_tx_active = r_tx_active;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  logic        clk;
  logic        i_rst;
  logic        i_baud_tick;
  logic [1:0]  i_req;
  logic [15:0] i_req_data;
  logic [7:0]  i_req_cfg;
  logic [1:0]  o_grant;
  logic [1:0]  o_ack;
  logic [1:0]  o_done;
  logic [0:0]  o_busy_id;
  logic        o_tx_serial;
  logic        o_tx_active;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_scheduler #(
    .N_REQ(2),
    .IDW  (1)
  ) dut (
    .i_clock    (clk),
    .i_rst      (i_rst),
    .i_baud_tick(i_baud_tick),
    .i_req      (i_req),
    .i_req_data (i_req_data),
    .i_req_cfg  (i_req_cfg),
    .o_grant    (o_grant),
    .o_ack      (o_ack),
    .o_done     (o_done),
    .o_busy_id  (o_busy_id),
    .o_tx_serial(o_tx_serial),
    .o_tx_active(o_tx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [3:0] c0;
    logic [3:0] c1;
    int         id;
    string      bits;        // expected line bits in transmit order
    bit         tick_latch;  // baud tick coincides with the latch edge
    bit         scramble;    // change data/cfg mid-frame
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Latch edge, then ticks every 16 clocks through the completion tick.
  task automatic do_frame(input logic [1:0] req, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [3:0] c0, input logic [3:0] c1, input int id,
                          input string bits, input bit drop, input bit tick_latch,
                          input bit scramble);
    logic [1:0] oh;
    logic       prev;
    logic       exp;
    int         n;
    oh = 2'b01 << id;
    n  = bits.len();
    i_req       = req;
    i_req_data  = {d1, d0};
    i_req_cfg   = {c1, c0};
    i_baud_tick = tick_latch;
    step();
    i_baud_tick = 1'b0;
    chk("latch_ack", 32'(o_ack), 32'(oh));
    chk("latch_grant", 32'(o_grant), 32'(oh));
    chk("latch_busy_id", 32'(o_busy_id), id);
    chk("latch_active", 32'(o_tx_active), 1);
    chk("latch_line_idle", 32'(o_tx_serial), 1);
    chk("latch_no_done", 32'(o_done), 0);
    if (drop) i_req = 2'b00;
    prev = 1'b1;
    for (int t = 1; t <= n + 1; t++) begin
      for (int c = 0; c < 15; c++) begin
        step();
        if (t == 1 && c == 0) chk("ack_one_cycle", 32'(o_ack), 0);
      end
      chk("line_hold", 32'(o_tx_serial), 32'(prev));
      i_baud_tick = 1'b1;
      step();
      i_baud_tick = 1'b0;
      if (t <= n) begin
        exp = (bits.getc(t - 1) == 8'h31);
        chk($sformatf("bit%0d", t - 1), 32'(o_tx_serial), 32'(exp));
        chk("no_early_done", 32'(o_done), 0);
        chk("grant_held", 32'(o_grant), 32'(oh));
        prev = exp;
        if (scramble && t == 3) begin
          i_req_data = ~{d1, d0};
          i_req_cfg  = ~{c1, c0};
        end
      end else begin
        chk("done_pulse", 32'(o_done), 32'(oh));
        chk("end_active", 32'(o_tx_active), 0);
        chk("end_grant", 32'(o_grant), 0);
        chk("end_line", 32'(o_tx_serial), 1);
      end
    end
  endtask

  initial begin
    vecs[0] = '{2'b01, 8'h55, 8'h00, 4'b0000, 4'b0000, 0, "010101011",    1'b0, 1'b0};
    vecs[1] = '{2'b01, 8'h03, 8'h00, 4'b0101, 4'b0000, 0, "01100000011",  1'b0, 1'b1};
    vecs[2] = '{2'b01, 8'h07, 8'h00, 4'b1011, 4'b0000, 0, "011100000111", 1'b0, 1'b0};
    vecs[3] = '{2'b10, 8'h00, 8'hA5, 4'b0000, 4'b0010, 1, "0101001011",   1'b0, 1'b0};
    vecs[4] = '{2'b01, 8'h80, 8'h00, 4'b1100, 4'b0000, 0, "000000001",    1'b0, 1'b0};
    vecs[5] = '{2'b01, 8'h00, 8'h00, 4'b0100, 4'b0000, 0, "0000000011",   1'b1, 1'b0};
    vecs[6] = '{2'b10, 8'h00, 8'hFF, 4'b0000, 4'b1001, 1, "01111111101",  1'b0, 1'b1};

    i_rst       = 1'b1;
    i_baud_tick = 1'b0;
    i_req       = 2'b00;
    i_req_data  = '0;
    i_req_cfg   = '0;
    step();
    step();
    chk("rst_line", 32'(o_tx_serial), 1);
    chk("rst_active", 32'(o_tx_active), 0);
    chk("rst_grant", 32'(o_grant), 0);
    chk("rst_ack", 32'(o_ack), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_busy_id", 32'(o_busy_id), 0);
    i_rst = 1'b0;
    step();

    for (int v = 0; v < 7; v++) begin
      do_frame(vecs[v].req, vecs[v].d0, vecs[v].d1, vecs[v].c0, vecs[v].c1, vecs[v].id,
               vecs[v].bits, 1'b1, vecs[v].tick_latch, vecs[v].scramble);
    end

    // Idle with no requests: ticks must not start anything.
    i_req = 2'b00;
    step();
    chk("idle_done_clear", 32'(o_done), 0);
    for (int c = 0; c < 20; c++) begin
      i_baud_tick = (c % 5 == 0);
      step();
    end
    i_baud_tick = 1'b0;
    chk("idle_active", 32'(o_tx_active), 0);
    chk("idle_line", 32'(o_tx_serial), 1);
    chk("idle_grant", 32'(o_grant), 0);

    // Both requesters held: grants alternate starting at 0 (last winner was 1).
    for (int f = 0; f < 4; f++) begin
      if (f % 2 == 0)
        do_frame(2'b11, 8'h55, 8'h0F, 4'b0000, 4'b0001, 0, "010101011", 1'b0, 1'b0, 1'b0);
      else
        do_frame(2'b11, 8'h55, 8'h0F, 4'b0000, 4'b0001, 1, "0111100001", 1'b0, 1'b0, 1'b0);
    end

    // Reset during the data bits aborts the frame.
    i_req      = 2'b01;
    i_req_data = 16'h0000;
    i_req_cfg  = 8'h01;
    step();
    chk("abort_latch_ack", 32'(o_ack), 1);
    chk("abort_latch_busy_id", 32'(o_busy_id), 0);
    i_req = 2'b00;
    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 15; c++) step();
      i_baud_tick = 1'b1;
      step();
      i_baud_tick = 1'b0;
    end
    chk("abort_mid_data", 32'(o_tx_serial), 0);
    i_rst = 1'b1;
    i_req = 2'b10;
    step();
    chk("abort_line", 32'(o_tx_serial), 1);
    chk("abort_grant", 32'(o_grant), 0);
    chk("abort_active", 32'(o_tx_active), 0);
    chk("abort_no_done", 32'(o_done), 0);
    chk("abort_busy_id", 32'(o_busy_id), 0);
    i_rst = 1'b0;
    do_frame(2'b10, 8'h00, 8'h3C, 4'b0000, 4'b0001, 1, "0001111001", 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
